// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a fixed-length burst from a synchronous FIFO and
// streams it out on a valid/ready interface, marking the final word.
// A 2-entry skid buffer hides the FIFO's one-cycle read latency so the
// stream can sustain one word per clock.
module fifo_burst_reader #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]  deliver_cnt_q, deliver_cnt_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  logic              pop;
  logic              rd_en;
  logic [2:0]        level;

  // Stream handshake and the pop rule: issue only if the buffer can still
  // take the word once everything already requested has landed.
  always_comb begin
    pop   = (occ_q != 2'd0) && m_ready_i;
    level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en = (state_q == ST_RUN) && !fifo_empty_i &&
            (issue_cnt_q != '0) && (level < 3'd2);
  end

  // Skid buffer: head is the word on the stream, tail holds the second one.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = rd_en;
    if (inflight_q && !pop) begin
      if (occ_q == 2'd0) begin
        head_d = fifo_data_i;
      end else begin
        tail_d = fifo_data_i;
      end
      occ_d = occ_q + 2'd1;
    end else if (!inflight_q && pop) begin
      head_d = tail_q;
      occ_d  = occ_q - 2'd1;
    end else if (inflight_q && pop) begin
      if (occ_q == 2'd1) begin
        head_d = fifo_data_i;
      end else begin
        head_d = tail_q;
        tail_d = fifo_data_i;
      end
    end
  end

  // Burst control: IDLE accepts a request, RUN issues reads, DRAIN waits for
  // the last word to be accepted by the sink.
  always_comb begin
    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    deliver_cnt_d = deliver_cnt_q;
    done_d        = 1'b0;
    if (pop && (deliver_cnt_q != '0)) begin
      deliver_cnt_d = deliver_cnt_q - 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            issue_cnt_d   = len_i;
            deliver_cnt_d = len_i;
            state_d       = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (rd_en) begin
          issue_cnt_d = issue_cnt_q - 1'b1;
          if (issue_cnt_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && (deliver_cnt_q == {{(LEN_W-1){1'b0}}, 1'b1})) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any burst in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      issue_cnt_q   <= '0;
      deliver_cnt_q <= '0;
      occ_q         <= 2'd0;
      inflight_q    <= 1'b0;
      done_q        <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      deliver_cnt_q <= deliver_cnt_d;
      occ_q         <= occ_d;
      inflight_q    <= inflight_d;
      done_q        <= done_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign fifo_rd_en_o = rd_en;
  assign m_valid_o    = (occ_q != 2'd0);
  assign m_data_o     = head_q;
  assign m_last_o     = (occ_q != 2'd0) && (deliver_cnt_q == {{(LEN_W-1){1'b0}}, 1'b1});

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed testbench for fifo_burst_reader with a behavioural FIFO model
// (one-cycle read latency) and a stream monitor.
module tb_fifo_burst_reader;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy, done, rd_en;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_data = '0;
  logic              m_valid, m_last;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] in_q[$];
  logic [DATA_W-1:0] slow_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic              clear_req = 1'b0;
  logic              toggle_ready = 1'b0;
  int                slow_timer = 0;

  int done_cnt, done_cyc, last_cnt, last_idx, last_cyc, first_cyc, viol, rd_seen, busy_seen;
  int start_cyc;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  fifo_burst_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len),
    .busy_o(busy), .done_o(done),
    .fifo_empty_i(fifo_empty), .fifo_rd_en_o(rd_en), .fifo_data_i(fifo_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: pop on the edge that samples rd_en, data appears after it.
  always @(posedge clk) begin
    if (clear_req) fifo_q.delete();
    if (rd_en && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
    while (in_q.size() != 0) fifo_q.push_back(in_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Stream monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rd_en && fifo_empty) viol++;
    if (rd_en) rd_seen++;
    if (busy) busy_seen++;
    if (dut.occ_q > 2'd2) viol++;
    if (prev_stall && !rst && (!m_valid || m_data !== prev_data)) viol++;
    prev_stall = m_valid && !m_ready && !rst;
    prev_data  = m_data;
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      if (first_cyc < 0) first_cyc = cyc;
      if (m_last) begin
        last_cnt++;
        last_idx = got_q.size();
        last_cyc = cyc;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) viol++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    if (toggle_ready) m_ready = ~m_ready;
    if (slow_q.size() != 0) begin
      if (slow_timer == 0) begin
        in_q.push_back(slow_q.pop_front());
        slow_timer = 2;
      end else begin
        slow_timer--;
      end
    end
  endtask

  task automatic clearAcc();
    got_q.delete();
    exp_q.delete();
    done_cnt = 0; done_cyc = -1; last_cnt = 0; last_idx = -1; last_cyc = -1;
    first_cyc = -1; viol = 0; rd_seen = 0; busy_seen = 0;
  endtask

  task automatic preload(input int n);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = DATA_W'($urandom);
      in_q.push_back(w);
      exp_q.push_back(w);
    end
    stepCycle();
    stepCycle();
  endtask

  task automatic applyStimulus(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len = l;
    start_cyc = cyc;
    stepCycle();
    start = 1'b0;
    len = '0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      stepCycle();
      k++;
    end
    checkOutput(tag, 32'(k < budget), 32'd1);
  endtask

  task automatic checkData(input string tag, input int n);
    logic [DATA_W-1:0] g;
    checkOutput({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      checkOutput({tag, "_word"}, 32'(g), 32'(exp_q[i]));
    end
  endtask

  initial begin
    clearAcc();
    // Reset state
    rst = 1'b1;
    #2;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
    checkOutput("rst_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_last", 32'(m_last), 32'd0);
    checkOutput("rst_data", 32'(m_data), 32'd0);
    stepCycle();
    stepCycle();
    rst = 1'b0;
    stepCycle();

    // Back-to-back burst of 20 out of 25 preloaded words
    clearAcc();
    m_ready = 1'b1;
    preload(25);
    applyStimulus(8'd20);
    waitDone("t1_timeout", 200);
    stepCycle();
    checkData("t1", 20);
    checkOutput("t1_first_latency", 32'(first_cyc - start_cyc), 32'd3);
    checkOutput("t1_span", 32'(last_cyc - first_cyc), 32'd19);
    checkOutput("t1_last_cnt", 32'(last_cnt), 32'd1);
    checkOutput("t1_last_idx", 32'(last_idx), 32'd20);
    checkOutput("t1_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("t1_done_cyc", 32'(done_cyc - last_cyc), 32'd1);
    checkOutput("t1_fifo_left", 32'(fifo_q.size()), 32'd5);
    checkOutput("t1_viol", 32'(viol), 32'd0);

    // Same burst with the sink stalling every other cycle
    clear_req = 1'b1;
    stepCycle();
    clearAcc();
    preload(25);
    toggle_ready = 1'b1;
    applyStimulus(8'd20);
    waitDone("t2_timeout", 300);
    toggle_ready = 1'b0;
    m_ready = 1'b1;
    stepCycle();
    checkData("t2", 20);
    checkOutput("t2_last_idx", 32'(last_idx), 32'd20);
    checkOutput("t2_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("t2_fifo_left", 32'(fifo_q.size()), 32'd5);
    checkOutput("t2_viol", 32'(viol), 32'd0);

    // Empty FIFO filled slowly during the burst
    clear_req = 1'b1;
    stepCycle();
    stepCycle();
    clearAcc();
    for (int i = 0; i < 8; i++) begin
      slow_q.push_back(DATA_W'($urandom));
      exp_q.push_back(slow_q[i]);
    end
    slow_timer = 2;
    applyStimulus(8'd8);
    waitDone("t3_timeout", 300);
    stepCycle();
    checkData("t3", 8);
    checkOutput("t3_last_idx", 32'(last_idx), 32'd8);
    checkOutput("t3_done_cyc", 32'(done_cyc - last_cyc), 32'd1);
    checkOutput("t3_viol", 32'(viol), 32'd0);

    // Zero-length burst
    clearAcc();
    applyStimulus(8'd0);
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("t4_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("t4_done_cyc", 32'(done_cyc - start_cyc), 32'd1);
    checkOutput("t4_rd_seen", 32'(rd_seen), 32'd0);
    checkOutput("t4_busy_seen", 32'(busy_seen), 32'd0);

    // Reset in the middle of a 10-word burst, then a clean 3-word burst
    clear_req = 1'b1;
    stepCycle();
    clearAcc();
    preload(10);
    applyStimulus(8'd10);
    for (int k = 0; k < 100 && got_q.size() < 4; k++) stepCycle();
    checkOutput("t5_reached4", 32'(got_q.size() >= 4), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_rd_en", 32'(rd_en), 32'd0);
    checkOutput("t5_valid", 32'(m_valid), 32'd0);
    checkOutput("t5_last", 32'(m_last), 32'd0);
    checkOutput("t5_data", 32'(m_data), 32'd0);
    stepCycle();
    stepCycle();
    rst = 1'b0;
    clear_req = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("t5_no_done", 32'(done_cnt), 32'd0);
    clearAcc();
    preload(3);
    applyStimulus(8'd3);
    waitDone("t5b_timeout", 100);
    stepCycle();
    checkData("t5b", 3);
    checkOutput("t5b_last_idx", 32'(last_idx), 32'd3);
    checkOutput("t5b_done_cnt", 32'(done_cnt), 32'd1);

    // Second start mid-burst must be ignored
    clear_req = 1'b1;
    stepCycle();
    clearAcc();
    preload(15);
    applyStimulus(8'd10);
    for (int i = 0; i < 3; i++) stepCycle();
    applyStimulus(8'd5);
    waitDone("t6_timeout", 200);
    for (int i = 0; i < 10; i++) stepCycle();
    checkData("t6", 10);
    checkOutput("t6_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("t6_last_cnt", 32'(last_cnt), 32'd1);
    checkOutput("t6_fifo_left", 32'(fifo_q.size()), 32'd5);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_viol", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side engine for the synchronous FIFO. On a start command it pops exactly `len_i` words from the FIFO and presents them on a valid/ready stream, flagging the final word with `m_last_o`. A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency, so the stream runs at one word per clock while the FIFO is non-empty and the sink is ready. It sits between `synchronous_fifo` and any downstream consumer.

## Interface
Parameters:
- `DATA_W`, 16: width of FIFO and stream data.
- `LEN_W`, 8: width of the burst length; bursts are 0..2^LEN_W-1 words.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  burst request; sampled only in IDLE.
- `len_i`  in  LEN_W  burst length; sampled together with `start_i`.
- `busy_o`  out  1  high in RUN and DRAIN.
- `done_o`  out  1  one-cycle pulse at burst completion.
- `fifo_empty_i`  in  1  FIFO empty flag.
- `fifo_rd_en_o`  out  1  FIFO pop strobe.
- `fifo_data_i`  in  DATA_W  FIFO read data, valid the cycle after the edge that sampled `fifo_rd_en_o`.
- `m_valid_o`  out  1  stream data valid.
- `m_ready_i`  in  1  stream sink ready.
- `m_data_o`  out  DATA_W  stream data; equals the skid-buffer head.
- `m_last_o`  out  1  high with the final word of the burst.

## Operation
- The FSM has three states: IDLE, RUN and DRAIN.
  - IDLE with `start_i`=1 and `len_i`!=0: latch `issue_cnt` = `len_i` and `deliver_cnt` = `len_i`, then go to RUN.
  - IDLE with `start_i`=1 and `len_i`=0: `done_o` pulses the next cycle, no pops occur, and the FSM stays in IDLE.
  - RUN to DRAIN when the last read is issued (`issue_cnt` reaches 0).
  - DRAIN to IDLE on the handshake of the word with `m_last_o`=1. `done_o` pulses in the following cycle.
- `start_i` is ignored while `busy_o`=1.
- The pop rule is combinational: `fifo_rd_en_o` = RUN & !`fifo_empty_i` & (`issue_cnt`!=0) & (`occ` + `inflight` - `pop`) < 2.
  - `occ` is the skid-buffer occupancy (0..2).
  - `inflight` is 1 if a read was issued in the previous cycle.
  - `pop` = `m_valid_o` & `m_ready_i`.
- Each cycle with `fifo_rd_en_o`=1 decrements `issue_cnt`. The returned word is written to the buffer tail on the next edge.
- `m_valid_o` = (`occ`!=0). Each handshake removes the head and decrements `deliver_cnt`.
- `m_last_o` = `m_valid_o` & (`deliver_cnt`==1).
- A simultaneous write and pop keeps `occ` unchanged.
- Buffer overflow is impossible by construction. The verifier asserts `occ`<=2 at all times.
- `m_valid_o` never drops, and `m_data_o` never changes, while `m_ready_i`=0.
- `fifo_rd_en_o` is never asserted while `fifo_empty_i`=1.

## Timing
- Reset (async assert, sync release): FSM=IDLE, counters=0, `occ`=0, `inflight`=0. All outputs read 0: `busy_o`, `done_o`, `fifo_rd_en_o`, `m_valid_o`, `m_last_o`, and `m_data_o`=0.
- Reset mid-burst aborts the burst. In-flight and buffered words are discarded and `done_o` does not pulse.
- Latency: `start_i` is sampled at edge 0.
  - `fifo_rd_en_o` can be high in the cycle after edge 0.
  - The first `m_valid_o` is high after edge 2.
- Throughput: 1 word/clock with the FIFO non-empty and `m_ready_i` held at 1.
- Sink stall: once `occ`=2 with no pop, `fifo_rd_en_o` drops the same cycle. Issue resumes in the cycle where `m_ready_i` returns.
- FIFO running empty mid-burst: issue pauses with no state change and resumes when `fifo_empty_i` falls.
- `done_o` is high for exactly one cycle: the cycle after the last handshake. `busy_o` falls on that same edge.
- `len_i`=2^LEN_W-1: the counters must not wrap; `issue_cnt` stops at 0.

## Test plan
- Preload 25 words (16-bit random), keep `m_ready_i`=1, start with `len_i`=20 -> 20 words out in FIFO order on 20 consecutive cycles. `m_last_o` is set on word 20 only, `done_o` pulses once, and 5 words remain in the FIFO.
- Same burst with `m_ready_i` toggling 1/0 every cycle -> identical data order, no duplicated or dropped words. `m_data_o` is stable during stalls and the skid-buffer occupancy never exceeds 2.
- Empty FIFO, start with `len_i`=8, then push 8 words at the rate of one every 3 cycles -> `fifo_rd_en_o` is never high while empty, 8 words are delivered and `done_o` pulses after the 8th.
- `len_i`=0 -> `done_o` pulses the next cycle, `fifo_rd_en_o` stays 0 and `busy_o` stays 0.
- Assert `rst_i` after 4 of 10 words have been delivered -> all outputs go to 0 asynchronously and there is no `done_o`. A new `len_i`=3 burst then completes normally.
- `start_i` pulsed again mid-burst with `len_i`=5 -> ignored. The original burst length is honored and exactly one `done_o` pulse occurs.
